// File: rtl/jpeg_pkg.sv
// rtl/jpeg_pkg.sv - shared widths, zigzag map and saturation helpers for the dequant stage
package jpeg_pkg;

    localparam int COEF_W = 16;
    localparam int Q_W    = 8;
    localparam int OUT_W  = 16;
    localparam int PROD_W = COEF_W + Q_W + 1;
    localparam int NCOEF  = 64;

    typedef enum logic {
        BANK_EMPTY = 1'b0,
        BANK_FULL  = 1'b1
    } bank_state_e;

    localparam logic signed [PROD_W-1:0] SAT_MAX = {{(PROD_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [PROD_W-1:0] SAT_MIN = {{(PROD_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    // Zigzag scan position -> natural row*8+col position.
    localparam logic [5:0] ZZ2NAT_TBL [NCOEF] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    function automatic logic [5:0] zz2nat(input logic [5:0] zz);
        return ZZ2NAT_TBL[zz];
    endfunction

    function automatic logic [OUT_W-1:0] sat_out(input logic signed [PROD_W-1:0] p);
        if (p > SAT_MAX) begin
            return SAT_MAX[OUT_W-1:0];
        end else if (p < SAT_MIN) begin
            return SAT_MIN[OUT_W-1:0];
        end
        return p[OUT_W-1:0];
    endfunction

    // Quant entries are unsigned, so they get a zero sign bit before the signed multiply.
    function automatic logic [OUT_W-1:0] dequant(input logic signed [COEF_W-1:0] coef,
                                                  input logic [Q_W-1:0] q);
        logic signed [PROD_W-1:0] a;
        logic signed [PROD_W-1:0] b;
        logic signed [PROD_W-1:0] p;
        a = PROD_W'(coef);
        b = PROD_W'($signed({1'b0, q}));
        p = a * b;
        return sat_out(p);
    endfunction

endpackage

// File: rtl/jpeg_dezigzag_dequant_if.sv
// rtl/jpeg_dezigzag_dequant_if.sv - quant-table, coefficient and block buses of the dequant stage
interface jpeg_dezigzag_dequant_if;
    import jpeg_pkg::*;

    logic                   qt_wr_en;
    logic [5:0]             qt_wr_addr;
    logic [Q_W-1:0]         qt_wr_data;

    logic                   coef_valid;
    logic                   coef_ready;
    logic [COEF_W-1:0]      coef_data;
    logic [5:0]             coef_zz_idx;
    logic                   coef_last;

    logic                   blk_valid;
    logic                   blk_ready;
    logic [NCOEF*OUT_W-1:0] blk_data;
    logic [15:0]            blk_cnt;

    modport master (
        output qt_wr_en, qt_wr_addr, qt_wr_data,
        output coef_valid, coef_data, coef_zz_idx, coef_last,
        output blk_ready,
        input  coef_ready, blk_valid, blk_data, blk_cnt
    );

    modport slave (
        input  qt_wr_en, qt_wr_addr, qt_wr_data,
        input  coef_valid, coef_data, coef_zz_idx, coef_last,
        input  blk_ready,
        output coef_ready, blk_valid, blk_data, blk_cnt
    );

endinterface

// File: rtl/jpeg_qtable.sv
// rtl/jpeg_qtable.sv - 64-entry quantisation table, synchronous write, combinational read
module jpeg_qtable
    import jpeg_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           wr_en_i,
    input  logic [5:0]     wr_addr_i,
    input  logic [Q_W-1:0] wr_data_i,
    input  logic [5:0]     rd_addr_i,
    output logic [Q_W-1:0] rd_data_o
);

    logic [Q_W-1:0] qt_q [NCOEF];
    logic [Q_W-1:0] qt_d [NCOEF];

    always_comb begin
        qt_d = qt_q;
        if (wr_en_i) begin
            qt_d[wr_addr_i] = wr_data_i;
        end
    end

    // Identity table out of reset so coefficients pass through unscaled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCOEF; i++) begin
                qt_q[i] <= Q_W'(1);
            end
        end else begin
            qt_q <= qt_d;
        end
    end

    assign rd_data_o = qt_q[rd_addr_i];

endmodule

// File: rtl/jpeg_dezigzag_dequant.sv
// rtl/jpeg_dezigzag_dequant.sv - dequantise zigzag coefficients into ping-pong natural-order 8x8 blocks
module jpeg_dezigzag_dequant
    import jpeg_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    jpeg_dezigzag_dequant_if.slave bus
);

    logic [OUT_W-1:0] bank_q [2][NCOEF];
    logic [OUT_W-1:0] bank_d [2][NCOEF];
    bank_state_e      st_q [2];
    bank_state_e      st_d [2];
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [15:0]      cnt_q, cnt_d;

    logic [Q_W-1:0]   qt_rd;
    logic [5:0]       nat_idx;
    logic [OUT_W-1:0] deq;
    logic             accept;
    logic             xfer;

    jpeg_qtable u_qtable (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (bus.qt_wr_en),
        .wr_addr_i (bus.qt_wr_addr),
        .wr_data_i (bus.qt_wr_data),
        .rd_addr_i (bus.coef_zz_idx),
        .rd_data_o (qt_rd)
    );

    assign bus.coef_ready = (st_q[wr_bank_q] == BANK_EMPTY);
    assign bus.blk_valid  = (st_q[rd_bank_q] == BANK_FULL);
    assign bus.blk_cnt    = cnt_q;

    assign accept  = bus.coef_valid && bus.coef_ready;
    assign xfer    = bus.blk_valid && bus.blk_ready;
    assign nat_idx = zz2nat(bus.coef_zz_idx);
    assign deq     = dequant($signed(bus.coef_data), qt_rd);

    always_comb begin
        bus.blk_data = '0;
        for (int k = 0; k < NCOEF; k++) begin
            bus.blk_data[k*OUT_W +: OUT_W] = bank_q[rd_bank_q][k];
        end
    end

    // Accept and transfer never hit the same bank: a filling bank is empty, a draining one is full.
    always_comb begin
        bank_d    = bank_q;
        st_d      = st_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        cnt_d     = cnt_q;

        if (xfer) begin
            for (int k = 0; k < NCOEF; k++) begin
                bank_d[rd_bank_q][k] = '0;
            end
            st_d[rd_bank_q] = BANK_EMPTY;
            rd_bank_d       = ~rd_bank_q;
            cnt_d           = cnt_q + 16'd1;
        end

        if (accept) begin
            bank_d[wr_bank_q][nat_idx] = deq;
            if (bus.coef_last) begin
                st_d[wr_bank_q] = BANK_FULL;
                wr_bank_d       = ~wr_bank_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q    <= '{default: '{default: '0}};
            st_q      <= '{BANK_EMPTY, BANK_EMPTY};
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            bank_q    <= bank_d;
            st_q      <= st_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_jpeg_dezigzag_dequant.sv
// tb/tb_jpeg_dezigzag_dequant.sv - self-checking bench for jpeg_dezigzag_dequant
module tb_jpeg_dezigzag_dequant;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    jpeg_dezigzag_dequant_if ifc ();

    jpeg_dezigzag_dequant dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    int n_chk  = 0;
    int n_fail = 0;

    int            zz_nat [64];
    int            m_qt   [64];
    logic [1023:0] m_cur;
    logic [1023:0] m_pend [$];
    int            m_cnt;

    typedef struct {
        logic [5:0] zz;
        int         coef;
        int         qv;
        int         nat;
        int         expv;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string nm, input logic [1023:0] got, input logic [1023:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic chk16(input string nm, input logic [15:0] got, input logic [15:0] exp);
        chk(nm, {1008'd0, got}, {1008'd0, exp});
    endtask

    function automatic int satm(input int p);
        if (p > 32767) return 32767;
        if (p < -32768) return -32768;
        return p;
    endfunction

    // Walk the anti-diagonals of the 8x8 block to derive the zigzag scan order.
    task automatic build_zigzag();
        int n = 0;
        for (int s = 0; s < 15; s++) begin
            if (s % 2 == 0) begin
                for (int r = (s < 8) ? s : 7; r >= 0 && (s - r) < 8; r--) begin
                    zz_nat[n] = r * 8 + (s - r);
                    n++;
                end
            end else begin
                for (int c = (s < 8) ? s : 7; c >= 0 && (s - c) < 8; c--) begin
                    zz_nat[n] = (s - c) * 8 + c;
                    n++;
                end
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_qt[i] = 1;
        m_cur = '0;
        m_pend.delete();
        m_cnt = 0;
    endtask

    // One clock: drive at negedge, check outputs against the model, step the model at posedge.
    task automatic cycle(input logic v, input logic [5:0] idx, input logic [15:0] d, input logic last,
                         input logic rdy, input logic qwe, input logic [5:0] qa, input logic [7:0] qd,
                         output logic acc);
        logic xf;
        logic signed [15:0] ds;
        ifc.coef_valid  = v;
        ifc.coef_zz_idx = idx;
        ifc.coef_data   = d;
        ifc.coef_last   = last;
        ifc.blk_ready   = rdy;
        ifc.qt_wr_en    = qwe;
        ifc.qt_wr_addr  = qa;
        ifc.qt_wr_data  = qd;
        #1;
        chk("blk_valid", {1023'd0, ifc.blk_valid}, {1023'd0, (m_pend.size() > 0)});
        chk("coef_ready", {1023'd0, ifc.coef_ready}, {1023'd0, (m_pend.size() < 2)});
        chk16("blk_cnt", ifc.blk_cnt, 16'(m_cnt));
        if (m_pend.size() > 0) chk("blk_data", ifc.blk_data, m_pend[0]);
        acc = v && (m_pend.size() < 2);
        xf  = rdy && (m_pend.size() > 0);
        @(posedge clk);
        if (xf) begin
            void'(m_pend.pop_front());
            m_cnt = (m_cnt + 1) & 16'hFFFF;
        end
        if (acc) begin
            ds = d;
            m_cur[zz_nat[idx]*16 +: 16] = 16'(satm(int'(ds) * m_qt[idx]));
            if (last) begin
                m_pend.push_back(m_cur);
                m_cur = '0;
            end
        end
        if (qwe) m_qt[qa] = int'(qd);
        @(negedge clk);
    endtask

    task automatic send(input logic [5:0] idx, input int val, input logic last);
        logic acc = 1'b0;
        for (int t = 0; t < 20 && !acc; t++) begin
            cycle(1'b1, idx, 16'(val), last, 1'b0, 1'b0, 6'd0, 8'd0, acc);
        end
        if (!acc) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: got no accept expected accept within 20 cycles");
        end
        ifc.coef_valid = 1'b0;
    endtask

    task automatic idle(input logic rdy);
        logic acc;
        cycle(1'b0, 6'd0, 16'd0, 1'b0, rdy, 1'b0, 6'd0, 8'd0, acc);
    endtask

    task automatic qtw(input logic [5:0] a, input int v);
        logic acc;
        cycle(1'b0, 6'd0, 16'd0, 1'b0, 1'b0, 1'b1, a, 8'(v), acc);
    endtask

    logic [1023:0] e;
    logic          acc_r;
    logic          have_c;
    logic [5:0]    c_idx;
    logic [15:0]   c_d;
    logic          c_last;
    logic          rdy_r, qwe_r;
    logic [5:0]    qa_r;
    logic [7:0]    qd_r;

    initial begin
        vecs[0] = '{zz: 6'd0,  coef: 1000,   qv: 255, nat: 0,  expv: 32767};
        vecs[1] = '{zz: 6'd1,  coef: -3,     qv: 16,  nat: 1,  expv: -48};
        vecs[2] = '{zz: 6'd0,  coef: -1000,  qv: 255, nat: 0,  expv: -32768};
        vecs[3] = '{zz: 6'd10, coef: -1,     qv: 255, nat: 32, expv: -255};
        vecs[4] = '{zz: 6'd35, coef: 200,    qv: 200, nat: 56, expv: 32767};
        vecs[5] = '{zz: 6'd20, coef: -32768, qv: 1,   nat: 40, expv: -32768};
        vecs[6] = '{zz: 6'd63, coef: -5,     qv: 100, nat: 63, expv: -500};
        vecs[7] = '{zz: 6'd4,  coef: 128,    qv: 255, nat: 9,  expv: 32640};
        vecs[8] = '{zz: 6'd6,  coef: -129,   qv: 254, nat: 3,  expv: -32766};

        build_zigzag();
        model_reset();
        ifc.coef_valid = 1'b0; ifc.coef_zz_idx = '0; ifc.coef_data = '0; ifc.coef_last = 1'b0;
        ifc.blk_ready = 1'b0; ifc.qt_wr_en = 1'b0; ifc.qt_wr_addr = '0; ifc.qt_wr_data = '0;

        repeat (2) @(negedge clk);
        chk("rst_blk_valid", {1023'd0, ifc.blk_valid}, 1024'd0);
        chk("rst_coef_ready", {1023'd0, ifc.coef_ready}, 1024'd1);
        chk16("rst_blk_cnt", ifc.blk_cnt, 16'd0);
        chk("rst_blk_data", ifc.blk_data, 1024'd0);
        rst_n = 1'b1;

        send(6'd0, 1000, 1'b1);
        e = '0; e[0 +: 16] = 16'd1000;
        chk("single_dc_valid", {1023'd0, ifc.blk_valid}, 1024'd1);
        chk("single_dc_block", ifc.blk_data, e);
        idle(1'b1);

        send(6'd2, 5, 1'b0);
        send(6'd3, -7, 1'b0);
        send(6'd5, 9, 1'b0);
        send(6'd63, 100, 1'b1);
        e = '0;
        e[8*16 +: 16] = 16'd5; e[16*16 +: 16] = 16'hFFF9;
        e[2*16 +: 16] = 16'd9; e[63*16 +: 16] = 16'd100;
        chk("scatter_block", ifc.blk_data, e);
        idle(1'b1);

        send(6'd0, 11, 1'b0);
        send(6'd1, 22, 1'b0);
        send(6'd2, 33, 1'b1);
        send(6'd0, 44, 1'b0);
        send(6'd4, 55, 1'b1);
        chk("bp_coef_ready_low", {1023'd0, ifc.coef_ready}, 1024'd0);
        chk16("bp_first_dc", ifc.blk_data[0 +: 16], 16'd11);
        idle(1'b1);
        chk16("bp_blk_cnt", ifc.blk_cnt, 16'd3);
        chk("bp_coef_ready_high", {1023'd0, ifc.coef_ready}, 1024'd1);
        chk16("bp_second_dc", ifc.blk_data[0 +: 16], 16'd44);
        chk16("bp_second_9", ifc.blk_data[9*16 +: 16], 16'd55);
        send(6'd1, 7, 1'b1);
        idle(1'b1);
        e = '0; e[1*16 +: 16] = 16'd7;
        chk("bp_no_residue", ifc.blk_data, e);
        idle(1'b1);

        for (int i = 0; i < 9; i++) begin
            qtw(vecs[i].zz, vecs[i].qv);
            send(vecs[i].zz, vecs[i].coef, 1'b1);
            chk16($sformatf("vec%0d_elem", i), ifc.blk_data[vecs[i].nat*16 +: 16], 16'(vecs[i].expv));
            idle(1'b1);
        end

        ifc.qt_wr_en = 1'b1; ifc.qt_wr_addr = 6'd12; ifc.qt_wr_data = 8'd3;
        ifc.coef_valid = 1'b1; ifc.coef_zz_idx = 6'd12; ifc.coef_data = 16'd100; ifc.coef_last = 1'b1;
        cycle(1'b1, 6'd12, 16'd100, 1'b1, 1'b0, 1'b1, 6'd12, 8'd3, acc_r);
        chk16("qt_same_cycle_old", ifc.blk_data[zz_nat[12]*16 +: 16], 16'd100);
        send(6'd12, 100, 1'b1);
        idle(1'b1);
        chk16("qt_next_cycle_new", ifc.blk_data[zz_nat[12]*16 +: 16], 16'd300);
        idle(1'b1);

        qtw(6'd7, 50);
        for (int i = 0; i < 10; i++) send(6'(i), 1000 + i, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_blk_valid", {1023'd0, ifc.blk_valid}, 1024'd0);
        chk("mid_rst_coef_ready", {1023'd0, ifc.coef_ready}, 1024'd1);
        chk16("mid_rst_blk_cnt", ifc.blk_cnt, 16'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        send(6'd7, 3, 1'b1);
        e = '0; e[10*16 +: 16] = 16'd3;
        chk("post_rst_block", ifc.blk_data, e);
        idle(1'b1);

        have_c = 1'b0; c_idx = '0; c_d = '0; c_last = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!have_c && ($urandom % 4 != 0)) begin
                have_c = 1'b1;
                c_idx  = 6'($urandom % 64);
                c_d    = ($urandom % 2 == 0) ? 16'($urandom) : 16'(int'($urandom % 512) - 256);
                c_last = ($urandom % 10 == 0);
            end
            rdy_r = ((n / 200) % 2 == 0) ? ($urandom % 3 != 0) : ($urandom % 8 == 0);
            qwe_r = ($urandom % 16 == 0);
            qa_r  = ($urandom % 2 == 0) ? c_idx : 6'($urandom % 64);
            qd_r  = 8'($urandom);
            cycle(have_c, c_idx, c_d, c_last, rdy_r, qwe_r, qa_r, qd_r, acc_r);
            if (acc_r) have_c = 1'b0;
        end
        for (int n = 0; n < 4; n++) idle(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/jpeg_dezigzag_dequant.md
Name: jpeg_dezigzag_dequant

Overview:
- Upstream neighbour of jpeg_idct_2d. Accepts the serial, zigzag-indexed, run-length-expanded coefficient stream from the Huffman/RLE decoder.
- Multiplies each coefficient by its quantisation-table entry, saturates the product, and scatters it into a natural (row-major) 8x8 block buffer.
- Presents each completed block as a flat 64x16 bus with a valid/ready handshake. jpeg_idct_2d consumes that bus directly.
- Double-buffered (ping-pong), so the decoder can fill one block while the IDCT side holds the other.

Parameters:
- COEF_W, 16, signed input coefficient width.
- Q_W, 8, unsigned quantisation entry width (baseline JPEG).
- OUT_W, 16, signed dequantised output width (matches the IDCT input).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- qt_wr_en  in  1  quant table write strobe.
- qt_wr_addr  in  6  table address, zigzag order (as in DQT).
- qt_wr_data  in  Q_W  table value.
- coef_valid  in  1  coefficient present.
- coef_ready  out  1  block accepts coefficient.
- coef_data  in  COEF_W  signed quantised coefficient.
- coef_zz_idx  in  6  zigzag position 0..63.
- coef_last  in  1  final coefficient of block (EOB).
- blk_valid  out  1  full block available.
- blk_ready  in  1  consumer takes block.
- blk_data  out  64*OUT_W  natural order; element k = row*8+col at [k*OUT_W +: OUT_W].
- blk_cnt  out  16  blocks delivered, wraps 0xFFFF->0.

Behaviour:
- Reset values (asynchronous assertion): both bank buffers 0, both full flags 0, wr_bank=0, rd_bank=0, blk_cnt=0, quant table all 1.
- Resulting outputs under reset: blk_valid=0, blk_data=0, coef_ready=1.
- Reset mid-block discards any partial block.
- coef_ready = !full[wr_bank]. This is combinational from registered state, with no path from coef_valid.
- Accept condition: coef_valid && coef_ready.
  - On accept, buf[wr_bank][ZZ2NAT[coef_zz_idx]] <= sat(coef_data * qt[coef_zz_idx]).
  - If coef_last is also set, full[wr_bank] <= 1 and wr_bank toggles.
- Stall: while coef_ready=0, upstream holds the coefficient stable. Nothing is written.
- Positions never written in a block remain 0, because banks are cleared on release.
- Index order is arbitrary. A duplicate index within a block means the last write wins.
- A block with only coef_last (e.g. index 0, value 0) is legal.
- Arithmetic: signed COEF_W times zero-extended Q_W gives a full-precision product. Saturate to [-32768, 32767].
- blk_valid = full[rd_bank]; blk_data = buf[rd_bank]. Both are registered state.
- Latency: coefficient with coef_last accepted at edge N -> blk_valid=1 after edge N, provided the other bank is not pending ahead of it.
- Transfer condition: blk_valid && blk_ready. On transfer:
  - buf[rd_bank] clears to 0 and full[rd_bank] <= 0.
  - rd_bank toggles and blk_cnt increments.
- blk_data is stable while blk_valid=1 and blk_ready=0.
- Simultaneous accept and transfer: they always target different banks (a write bank equal to rd_bank implies that bank is empty). Both take effect in the same edge.
  - If the write side was stalled on the bank being released, coef_ready rises the next cycle.
- Throughput:
  - One coefficient per cycle.
  - One block per cycle on the output when blk_ready=1.
  - With both banks full: coef_ready=0.
- Quant table writes are allowed at any time and take effect for coefficients accepted from the following cycle.
  - A qt write and a coefficient accept to the same address in the same cycle use the old value.
- Bank state per bank: EMPTY (filling or idle) -> FULL on last-accept -> EMPTY on transfer.

Decomposition:
- Shared package jpeg_pkg:
  - 64-entry ZZ2NAT constant/function (0,1,8,16,9,2,3,10,17,24,...).
  - Width constants COEF_W, Q_W, OUT_W.
  - Saturation function.
- One sub-module jpeg_qtable: 64 x Q_W register file, synchronous write, combinational read, resets to 1.
- Bank buffers, flags and the handshake stay in the top module.

Test Plan:
- Reset, then identity qt; send idx0=1000 with coef_last -> next cycle blk_valid=1, blk_data[0]=1000, other 63 elements 0.
- Identity qt; send idx2=5, idx3=-7, idx5=9, idx63=100 (coef_last) -> natural elements [8]=5, [16]=-7, [2]=9, [63]=100, rest 0.
- Program qt[0]=255, qt[1]=16; send idx0=1000 and idx1=-3 (last) -> [0]=32767 (saturated from 255000), [1]=-48.
  - Repeat with idx0=-1000 -> [0]=-32768.
- Hold blk_ready=0; send two full blocks -> coef_ready=0 after the second coef_last.
  - Then blk_ready=1 for one cycle -> first block out, blk_cnt=1.
  - Next cycle blk_data shows block 2 and coef_ready=1.
  - Block 3 contains only its written positions: no residue from block 1.
- Assert rst_n low mid-block (after 10 coefficients) -> immediately blk_valid=0, coef_ready=1, blk_cnt=0, qt back to 1.
  - A block sent after reset has no stale entries.
